// File: rtl/intr_pkg.sv
// Shared types and helpers for the priority interrupt controller.
package intr_pkg;

    // Arbitration FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Widest source vector the helpers support, and the index width that covers it.
    localparam int MAX_SRC = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } hi_t;

    // Index of the highest set bit, with a flag saying whether any bit is set.
    function automatic hi_t hi_index(input logic [MAX_SRC-1:0] v);
        hi_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_ctrl_n_if.sv
// CPU-side request/acknowledge/EOI handshake of the interrupt controller.
interface intr_ctrl_n_if #(
    parameter int VEC_W = 8
) ();
    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;
    logic             irq_ack;
    logic             irq_eoi;

    // Controller side: drives the request and vector.
    modport master (
        output irq_req,
        output irq_vec,
        input  irq_ack,
        input  irq_eoi
    );

    // CPU side: accepts the vector and retires routines.
    modport slave (
        input  irq_req,
        input  irq_vec,
        output irq_ack,
        output irq_eoi
    );
endinterface

// File: rtl/prio_enc_n.sv
// N-bit priority encoder: highest set index wins, valid when any bit is set.
module prio_enc_n
    import intr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    hi_t hit;

    // Zero-extend to the helper width; indices above N-1 can never be set.
    assign hit   = hi_index(MAX_SRC'(vec));
    assign valid = hit.valid;
    assign idx   = hit.idx;

endmodule

// File: rtl/intr_ctrl_n.sv
// Priority interrupt controller: latches edge/level sources, masks them,
// arbitrates with in-service nesting and hands one vector at a time to the
// CPU over a req/ack handshake, retiring routines on EOI.
module intr_ctrl_n
    import intr_pkg::*;
#(
    parameter int               N_SRC      = 8,
    parameter int               VEC_W      = 8,
    parameter int               VEC_BASE   = 0,
    parameter int               VEC_STRIDE = 1,
    parameter logic [N_SRC-1:0] EDGE_MODE  = '1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] src,
    input  logic [N_SRC-1:0] mask,
    input  logic             en,
    input  logic [N_SRC-1:0] clr_pend,
    intr_ctrl_n_if.master    bus,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service
);

    state_t           state;
    logic [IDX_W-1:0] win_idx;

    logic [N_SRC-1:0] src_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] above;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] win_oh;
    logic [N_SRC-1:0] ack_oh;
    logic [N_SRC-1:0] eoi_oh;

    logic             elig_vld;
    logic [IDX_W-1:0] elig_idx;
    logic             isv_vld;
    logic [IDX_W-1:0] isv_idx;
    logic             win_ok;
    logic             ack_fire;

    // Service-routine address for a source index, truncated to VEC_W.
    function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] i);
        logic [31:0] t;
        t = 32'(VEC_BASE) + 32'(i) * 32'(VEC_STRIDE);
        return t[VEC_W-1:0];
    endfunction

    prio_enc_n #(.N(N_SRC)) u_arb (
        .vec   (eligible),
        .valid (elig_vld),
        .idx   (elig_idx)
    );

    prio_enc_n #(.N(N_SRC)) u_isv (
        .vec   (in_service),
        .valid (isv_vld),
        .idx   (isv_idx)
    );

    // Eligibility: only sources strictly above the highest in-service one may preempt.
    always_comb begin
        above = '0;
        for (int i = 0; i < N_SRC; i++) begin
            above[i] = !isv_vld || (i > int'(isv_idx));
        end
        rise     = src & ~src_d;
        eligible = pending & mask & ~in_service & above;
        win_oh   = N_SRC'(1) << win_idx;
        win_ok   = en && (|(eligible & win_oh));
        ack_fire = (state == REQ) && bus.irq_ack && win_ok;
        ack_oh   = ack_fire ? win_oh : '0;
        eoi_oh   = (bus.irq_eoi && isv_vld) ? (N_SRC'(1) << isv_idx) : '0;
    end

    // Next pending: edge bits latch rises (set beats clear), level bits follow src.
    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (EDGE_MODE[i]) begin
                pend_nxt[i] = rise[i] | (pending[i] & ~(clr_pend[i] | ack_oh[i]));
            end else begin
                pend_nxt[i] = src[i];
            end
        end
    end

    // Source history and pending latch; src_d clears so a held source looks like an edge after reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            src_d   <= '0;
            pending <= '0;
        end else begin
            src_d   <= src;
            pending <= pend_nxt;
        end
    end

    // In-service tracking: EOI retires the previous highest bit, then ack adds the new one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            in_service <= '0;
        end else begin
            in_service <= (in_service & ~eoi_oh) | ack_oh;
        end
    end

    // Arbitration FSM; winner and vector are frozen for the whole request.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            win_idx     <= '0;
            bus.irq_req <= 1'b0;
            bus.irq_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && elig_vld) begin
                        state       <= REQ;
                        win_idx     <= elig_idx;
                        bus.irq_req <= 1'b1;
                        bus.irq_vec <= vec_of(elig_idx);
                    end
                end
                REQ: begin
                    // Withdrawal or acceptance both return to IDLE; only an accepted ack sets in_service.
                    if (!win_ok || bus.irq_ack) begin
                        state       <= IDLE;
                        bus.irq_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.irq_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Directed bench for intr_ctrl_n: source 4 is level-sensitive, all others edge.
module tb_intr_ctrl_n;

    logic       clk;
    logic       clr;
    logic [7:0] src;
    logic [7:0] mask;
    logic       en;
    logic [7:0] clr_pend;
    logic [7:0] pending;
    logic [7:0] in_service;

    int total;
    int bad;

    intr_ctrl_n_if #(.VEC_W(8)) bus_if ();

    intr_ctrl_n #(
        .N_SRC      (8),
        .VEC_W      (8),
        .VEC_BASE   (0),
        .VEC_STRIDE (1),
        .EDGE_MODE  (8'hEF)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .src        (src),
        .mask       (mask),
        .en         (en),
        .clr_pend   (clr_pend),
        .bus        (bus_if),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr = 1'b0; src = 8'h00; mask = 8'hFF; en = 1'b1; clr_pend = 8'h00;
        bus_if.irq_ack = 1'b0; bus_if.irq_eoi = 1'b0;

        // Reset state
        step(); step();
        chk("rst_req", 32'(bus_if.irq_req), 32'h0);
        chk("rst_vec", 32'(bus_if.irq_vec), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_isv", 32'(in_service), 32'h0);
        clr = 1'b1;
        step();

        // Single edge source 2
        src = 8'h04;
        step();
        chk("t1_pend", 32'(pending), 32'h04);
        chk("t1_req_early", 32'(bus_if.irq_req), 32'h0);
        src = 8'h00;
        step();
        chk("t1_req", 32'(bus_if.irq_req), 32'h1);
        chk("t1_vec", 32'(bus_if.irq_vec), 32'h02);
        bus_if.irq_ack = 1'b1;
        step();
        bus_if.irq_ack = 1'b0;
        chk("t1_req_ack", 32'(bus_if.irq_req), 32'h0);
        chk("t1_pend_ack", 32'(pending), 32'h00);
        chk("t1_isv", 32'(in_service), 32'h04);
        step();
        chk("t1_req_idle", 32'(bus_if.irq_req), 32'h0);
        bus_if.irq_eoi = 1'b1;
        step();
        bus_if.irq_eoi = 1'b0;
        chk("t1_isv_eoi", 32'(in_service), 32'h00);

        // Sources 1 and 5 together, nesting blocks 1 until EOI
        src = 8'h22;
        step();
        src = 8'h00;
        chk("t2_pend", 32'(pending), 32'h22);
        step();
        chk("t2_req5", 32'(bus_if.irq_req), 32'h1);
        chk("t2_vec5", 32'(bus_if.irq_vec), 32'h05);
        bus_if.irq_ack = 1'b1;
        step();
        bus_if.irq_ack = 1'b0;
        chk("t2_isv5", 32'(in_service), 32'h20);
        chk("t2_pend1", 32'(pending), 32'h02);
        step();
        chk("t2_blocked", 32'(bus_if.irq_req), 32'h0);
        bus_if.irq_eoi = 1'b1;
        step();
        bus_if.irq_eoi = 1'b0;
        chk("t2_isv_eoi", 32'(in_service), 32'h00);
        step();
        chk("t2_req1", 32'(bus_if.irq_req), 32'h1);
        chk("t2_vec1", 32'(bus_if.irq_vec), 32'h01);
        bus_if.irq_ack = 1'b1;
        step();
        bus_if.irq_ack = 1'b0;
        chk("t2_isv1", 32'(in_service), 32'h02);
        bus_if.irq_eoi = 1'b1;
        step();
        bus_if.irq_eoi = 1'b0;
        chk("t2_isv_done", 32'(in_service), 32'h00);

        // Nested: 6 preempts 3
        src = 8'h08;
        step();
        src = 8'h00;
        step();
        chk("t3_vec3", 32'(bus_if.irq_vec), 32'h03);
        bus_if.irq_ack = 1'b1;
        step();
        bus_if.irq_ack = 1'b0;
        chk("t3_isv3", 32'(in_service), 32'h08);
        src = 8'h40;
        step();
        src = 8'h00;
        step();
        chk("t3_req6", 32'(bus_if.irq_req), 32'h1);
        chk("t3_vec6", 32'(bus_if.irq_vec), 32'h06);
        bus_if.irq_ack = 1'b1;
        step();
        bus_if.irq_ack = 1'b0;
        chk("t3_isv36", 32'(in_service), 32'h48);
        bus_if.irq_eoi = 1'b1;
        step();
        chk("t3_eoi1", 32'(in_service), 32'h08);
        step();
        bus_if.irq_eoi = 1'b0;
        chk("t3_eoi2", 32'(in_service), 32'h00);

        // Level source 4 drops while requesting
        src = 8'h10;
        step();
        chk("t4_pend", 32'(pending), 32'h10);
        step();
        chk("t4_req", 32'(bus_if.irq_req), 32'h1);
        chk("t4_vec", 32'(bus_if.irq_vec), 32'h04);
        src = 8'h00;
        step();
        step();
        chk("t4_abort", 32'(bus_if.irq_req), 32'h0);
        bus_if.irq_ack = 1'b1;
        step();
        bus_if.irq_ack = 1'b0;
        chk("t4_isv", 32'(in_service), 32'h00);
        chk("t4_req_after", 32'(bus_if.irq_req), 32'h0);

        // Global disable, clear vs. new edge
        en = 1'b0;
        src = 8'h04;
        step();
        src = 8'h00;
        chk("t5_pend", 32'(pending), 32'h04);
        step(); step();
        chk("t5_en_block", 32'(bus_if.irq_req), 32'h0);
        clr_pend = 8'h04;
        src = 8'h04;
        step();
        chk("t5_set_wins", 32'(pending), 32'h04);
        src = 8'h00;
        step();
        clr_pend = 8'h00;
        chk("t5_cleared", 32'(pending), 32'h00);

        // Asynchronous reset mid-request, held source re-seen as an edge
        en = 1'b1;
        src = 8'h04;
        step(); step();
        chk("t6_req", 32'(bus_if.irq_req), 32'h1);
        #2 clr = 1'b0;
        #1;
        chk("t6_rst_req", 32'(bus_if.irq_req), 32'h0);
        chk("t6_rst_vec", 32'(bus_if.irq_vec), 32'h0);
        chk("t6_rst_pend", 32'(pending), 32'h00);
        step();
        clr = 1'b1;
        step();
        chk("t6_pend_held", 32'(pending), 32'h04);
        chk("t6_req_early", 32'(bus_if.irq_req), 32'h0);
        step();
        chk("t6_req_again", 32'(bus_if.irq_req), 32'h1);
        chk("t6_vec", 32'(bus_if.irq_vec), 32'h02);
        src = 8'h00;
        bus_if.irq_ack = 1'b1;
        step();
        bus_if.irq_ack = 1'b0;
        chk("t6_isv", 32'(in_service), 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_ctrl_n.md
# intr_ctrl_n

Parametrised priority interrupt controller for the processor's control path: latches up to N_SRC interrupt sources (each independently edge- or level-sensitive), masks them, selects the highest-priority eligible request, and hands its service-routine address to the fetch unit through a req/ack handshake. It adds per-source clear, in-service tracking with priority nesting, and end-of-interrupt (EOI) retirement. It sits between the exception/flag sources (zero, overflow, illegal opcode, external pins) and the PC select logic.

## Interface
- N_SRC, 8: number of interrupt sources; index N_SRC-1 is highest priority.
- VEC_W, 8: vector (PC) width.
- VEC_BASE, 0: vector of source 0.
- VEC_STRIDE, 1: vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE, truncated to VEC_W.
- EDGE_MODE, all ones: per-source bit; 1 = rising-edge latched, 0 = level.
- clk  in  1  clock; all state on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- src  in  N_SRC  interrupt sources, synchronous to clk.
- mask  in  N_SRC  1 = source enabled.
- en  in  1  global interrupt enable.
- clr_pend  in  N_SRC  per-source pending clear, one-cycle pulses.
- irq_ack  in  1  CPU accepts current vector.
- irq_eoi  in  1  CPU finished highest in-service routine.
- irq_req  out  1  request to CPU.
- irq_vec  out  VEC_W  service-routine address, stable while irq_req = 1.
- pending  out  N_SRC  latched pending bits.
- in_service  out  N_SRC  routines currently being serviced.

## Operation
- Edge sources: src_d register holds previous src; pending[i] sets when src[i] & ~src_d[i]; clears on clr_pend[i] or on ack of i. Set and clear same cycle: set wins.
- Level sources: pending[i] = registered src[i]; clr_pend ignored; ack does not clear.
- Eligible = pending & mask & ~in_service, restricted to indices above the highest set in_service bit (nesting: only strictly higher priority preempts).
- FSM IDLE: if en and any eligible, go REQ; latch winning index win_idx and irq_vec = vector(win_idx).
- FSM REQ: irq_req = 1, win_idx/irq_vec frozen (a later higher-priority arrival waits for the next arbitration). On irq_ack: in_service[win_idx] = 1, edge pending[win_idx] cleared, go IDLE. If en drops, or win_idx is no longer eligible (cleared, level dropped, masked), abort to IDLE without setting in_service.
- irq_ack in IDLE: ignored.
- irq_eoi: clears highest set in_service bit; ignored if none. EOI and ack same cycle: EOI clears the previous highest bit, then ack sets the new bit.

## Timing
- Reset (clr low, asynchronous): pending = 0, in_service = 0, src_d = 0, FSM IDLE, irq_req = 0, irq_vec = 0. A source already high at reset release is seen as an edge.
- src rising sampled at edge k -> pending set after k -> irq_req = 1 and irq_vec valid after k+1 (2-cycle latency).
- irq_ack sampled at edge m -> irq_req = 0 after m; next arbitration no earlier than edge m+1 (irq_req may rise again after m+1).
- Abort: irq_req falls one cycle after the withdrawing condition is sampled.
- irq_req never asserts with irq_vec changing; no combinational path from inputs to outputs.

## Structure
- Package intr_pkg: FSM state enum (IDLE, REQ) and function hi_index(vector) returning the index of the highest set bit plus a valid flag.
- Sub-module prio_enc_n (parameter N): N-bit highest-index-wins encoder with valid output, instantiated for eligible arbitration and for EOI bit selection.

## Test plan
- Source 2 edge, mask = 8'hFF, en = 1 -> irq_req high 2 cycles later, irq_vec = 8'h02; ack -> pending[2] = 0, in_service = 8'h04, irq_req low next cycle.
- Sources 1 and 5 rise same cycle -> vector 8'h05 first; after ack, source 1 does not request (below in-service 5) until EOI, then vector 8'h01.
- Source 6 rises while 3 is in service -> nested request, vector 8'h06; two EOIs clear bit 6 then bit 3.
- Level source 4 (EDGE_MODE bit 4 = 0) drops while in REQ -> irq_req falls next cycle, later ack ignored, in_service = 0.
- clr_pend[2] in same cycle as a new rising edge on src[2] -> pending[2] remains 1; en = 0 blocks irq_req despite pending.
- clr pulsed low mid-REQ -> all outputs 0 immediately, no request until a new edge or held source.
